// File: rtl/neat_rng_pkg.sv
// Shared types and constants for the NEAT random-number path.
// Used by the generator-side buffer and its FIFO.
package neat_rng_pkg;

  localparam int RAND_W              = 32;
  localparam int RAND_PERIOD_DEFAULT = 3;
  localparam int DROP_W              = 16;

  typedef logic [RAND_W-1:0] rand_word_t;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// Synchronous FIFO holding sampled random words.
// Push is refused when full unless a pop frees a slot on the same edge.
module rand_fifo
  import neat_rng_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [RAND_W-1:0]        wr_data_i,
  output logic [RAND_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rand_word_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            push_ok_s;
  logic            pop_ok_s;

  always_comb begin
    pop_ok_s  = pop_i && (count_q != CW'(0));
    push_ok_s = push_i && (!full_q || pop_ok_s);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/rand_buffer.sv
// Samples the free-running xorwow output once per generation period and
// serves buffered words with a per-read unsigned threshold compare.
module rand_buffer
  import neat_rng_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int RAND_PERIOD = RAND_PERIOD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RAND_W-1:0]        random_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [RAND_W-1:0]        rd_data,
  input  logic [RAND_W-1:0]        thresh,
  output logic                     rd_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PW = (RAND_PERIOD > 1) ? $clog2(RAND_PERIOD) : 1;

  logic [PW-1:0]     phase_q, phase_d;
  logic              primed_q, primed_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              wrap_s;
  logic              smp_s;
  logic              pop_s;
  logic              drop_s;
  logic              empty_s;
  rand_word_t        head_s;

  // The first wrap marks the first generator update; sampling starts one edge later.
  always_comb begin
    wrap_s   = (phase_q == PW'(RAND_PERIOD - 1));
    phase_d  = wrap_s ? PW'(0) : phase_q + PW'(1);
    primed_d = primed_q | wrap_s;
    smp_s    = primed_q && (phase_q == PW'(0));
    pop_s    = !empty_s && rd_ready;
    drop_s   = smp_s && full && !pop_s;
    drop_d   = drop_s ? sat_inc(drop_q) : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      primed_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      primed_q <= primed_d;
      drop_q   <= drop_d;
    end
  end

  rand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (smp_s),
    .pop_i     (pop_s),
    .wr_data_i (random_in),
    .head_o    (head_s),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty_s)
  );

  always_comb begin
    rd_valid = !empty_s;
    if (empty_s) begin
      rd_data = '0;
      rd_hit  = 1'b0;
    end else begin
      rd_data = head_s;
      rd_hit  = (head_s < thresh);
    end
  end

  assign drop_cnt = drop_q;

endmodule
